// File: rtl/regfile_mp_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants for the multi-port register file:
//   RF_WIDTH / RF_DEPTH : default data width and register count
//   R0 .. R7            : 3-bit register-index names for the default 8-entry file
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int RF_WIDTH = 16;
   localparam int RF_DEPTH = 8;

   localparam logic [2:0] R0 = 3'd0;
   localparam logic [2:0] R1 = 3'd1;
   localparam logic [2:0] R2 = 3'd2;
   localparam logic [2:0] R3 = 3'd3;
   localparam logic [2:0] R4 = 3'd4;
   localparam logic [2:0] R5 = 3'd5;
   localparam logic [2:0] R6 = 3'd6;
   localparam logic [2:0] R7 = 3'd7;

endpackage

// File: rtl/regfile_mp_if.sv
// -----------------------------------------------------------------------------
// regfile_mp_if
// Bus between the datapath controller (master) and the register file (slave).
//   write/writenum/data_in     : write port
//   claim/claimnum             : mark a register busy (producer issued)
//   readnum_a/readnum_b        : read indices
//   data_out_a/data_out_b      : read data
//   busy_a/busy_b              : busy bit of the addressed registers
//   busy_any                   : OR of every busy bit
// -----------------------------------------------------------------------------
interface regfile_mp_if
   import regfile_pkg::*;
#(
   parameter int WIDTH = RF_WIDTH,
   parameter int DEPTH = RF_DEPTH
);
   localparam int AW = $clog2(DEPTH);

   logic             write;
   logic [AW-1:0]    writenum;
   logic [WIDTH-1:0] data_in;
   logic             claim;
   logic [AW-1:0]    claimnum;
   logic [AW-1:0]    readnum_a;
   logic [AW-1:0]    readnum_b;
   logic [WIDTH-1:0] data_out_a;
   logic [WIDTH-1:0] data_out_b;
   logic             busy_a;
   logic             busy_b;
   logic             busy_any;

   modport master (
      output write, writenum, data_in, claim, claimnum, readnum_a, readnum_b,
      input  data_out_a, data_out_b, busy_a, busy_b, busy_any
   );

   modport slave (
      input  write, writenum, data_in, claim, claimnum, readnum_a, readnum_b,
      output data_out_a, data_out_b, busy_a, busy_b, busy_any
   );

endinterface

// File: rtl/regfile_mp_cell.sv
// -----------------------------------------------------------------------------
// regfile_cell
// One WIDTH-bit storage register, synchronous reset to zero, load enable.
//   clk, reset : clock and synchronous active-high reset
//   i_load     : capture i_d on the rising edge
//   i_d        : data to load
//   o_q        : stored value
// -----------------------------------------------------------------------------
module regfile_cell
   import regfile_pkg::*;
#(
   parameter int WIDTH = RF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parametrised register file: one write port, two combinational read ports,
// synchronous clear and a per-register busy scoreboard.
//   clk, reset : clock and synchronous active-high reset (clears data and busy)
//   bus        : regfile_mp_if slave modport (write, claim, two read ports,
//                busy_a/busy_b/busy_any)
// Build option: define REGFILE_BYPASS_EN to forward data_in onto a read port
// that addresses the register being written in the same cycle. Busy bits are
// never forwarded.
// -----------------------------------------------------------------------------
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int WIDTH = RF_WIDTH,
   parameter int DEPTH = RF_DEPTH
) (
   input  logic          clk,
   input  logic          reset,
   regfile_mp_if.slave   bus
);

   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0] w_load;
   logic [DEPTH-1:0] w_claim;
   logic [DEPTH-1:0] r_busy;
   logic [WIDTH-1:0] w_q [DEPTH];

   // Index decode: an out-of-range index matches no register, so such writes
   // and claims fall away with no extra logic.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_reg
         assign w_load[gi]  = bus.write && (bus.writenum == AW'(gi));
         assign w_claim[gi] = bus.claim && (bus.claimnum == AW'(gi));

         regfile_cell #(.WIDTH(WIDTH)) u_cell (
            .clk    (clk),
            .reset  (reset),
            .i_load (w_load[gi]),
            .i_d    (bus.data_in),
            .o_q    (w_q[gi])
         );
      end
   endgenerate

   // Write-back clears busy; a claim in the same cycle is applied afterwards
   // so the newly issued producer keeps the register busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy <= '0;
      end else begin
         r_busy <= (r_busy & ~w_load) | w_claim;
      end
   end

   logic [WIDTH-1:0] w_data_a;
   logic [WIDTH-1:0] w_data_b;
   logic             w_busy_a;
   logic             w_busy_b;

   // Read muxes default to zero so out-of-range indices read 0 / not busy.
   always_comb begin
      w_data_a = '0;
      w_data_b = '0;
      w_busy_a = 1'b0;
      w_busy_b = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.readnum_a == AW'(i)) begin
            w_data_a = w_q[i];
            w_busy_a = r_busy[i];
`ifdef REGFILE_BYPASS_EN
            if (w_load[i] && !reset) begin
               w_data_a = bus.data_in;
            end
`endif
         end
         if (bus.readnum_b == AW'(i)) begin
            w_data_b = w_q[i];
            w_busy_b = r_busy[i];
`ifdef REGFILE_BYPASS_EN
            if (w_load[i] && !reset) begin
               w_data_b = bus.data_in;
            end
`endif
         end
      end
   end

   assign bus.data_out_a = w_data_a;
   assign bus.data_out_b = w_data_b;
   assign bus.busy_a     = w_busy_a;
   assign bus.busy_b     = w_busy_b;
   assign bus.busy_any   = |r_busy;

endmodule
